uart_rx_fifo: RTL and testbench

Hardware 8N1 UART receiver with a small receive FIFO and a word-addressed register port, replacing the bit-banged RX path (software polling the raw `uart_rx` pin). Sits in the I/O-mapped region beside the LED/TX registers. The wrapper decodes its window and forwards select, write-enable, word address and write data. It returns read data one cycle after the request, matching the registered-read timing of main and boot memory.

---
 rtl/uart_rx_fifo_if.sv | 16 +
 rtl/uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Register-port bundle between the I/O wrapper and uart_rx_fifo.
//   sel   : access to this block this cycle
//   wren  : access is a write
//   addr  : word address (0 DATA, 1 STATUS, 2 BITWIDTH, 3 reserved)
//   wdata : write data
//   rdata : registered read data, valid the cycle after sel & ~wren
interface uart_rx_fifo_if;
  logic        sel;
  logic        wren;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output wren, output addr, output wdata, input rdata);
  modport slave  (input sel, input wren, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO behind a word-addressed
// register port.
//   clk     : core clock
//   rst     : synchronous reset, active-high
//   uart_rx : asynchronous serial input, idle high
//   bus     : register port (slave side), see uart_rx_fifo_if
// Registers: DATA (pop, bit 8 = valid), STATUS ({count, frame_err, overrun,
// full, nonempty}, bits 3:2 write-1-to-clear), BITWIDTH (clocks per bit).
module uart_rx_fifo #(
  parameter int unsigned CLOCK_RATE = 24_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rx,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned BIT = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CW  = $clog2(BIT);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] A_DATA     = 2'd0;
  localparam logic [1:0] A_STATUS   = 2'd1;
  localparam logic [1:0] A_BITWIDTH = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer plus one history flop for falling-edge detection
  // ---------------------------------------------------------------------
  logic rx_meta, rxs, rxs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= uart_rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          push;
  logic          ferr_set;
  logic          expired;

  assign expired = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rxs_prev && !rxs) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end

      ST_START: begin
        if (expired) begin
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DATA: begin
        if (expired) begin
          shreg_d = {rxs, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_STOP: begin
        if (expired) begin
          if (rxs) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WAIT_HIGH: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          rd_req, st_wr;
  logic          nonempty, full;
  logic          pop, push_ok, ovr_set;
  logic          overrun_q, frame_err_q;

  assign rd_req   = bus.sel && !bus.wren;
  assign st_wr    = bus.sel && bus.wren && (bus.addr == A_STATUS);
  assign nonempty = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = rd_req && (bus.addr == A_DATA) && nonempty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok  = push && (!full || pop);
  assign ovr_set  = push && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags; a set in the same cycle beats a write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (st_wr && bus.wdata[2]) begin
        overrun_q <= 1'b0;
      end
      if (ferr_set) begin
        frame_err_q <= 1'b1;
      end else if (st_wr && bus.wdata[3]) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register read port
  // ---------------------------------------------------------------------
  logic [31:0] rd_mux;
  logic [3:0]  count4;

  assign count4 = 4'(count_q);

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_DATA:     rd_mux = nonempty ? {23'b0, 1'b1, mem[rd_ptr_q]} : '0;
      A_STATUS:   rd_mux = {24'b0, count4, frame_err_q, overrun_q, full, nonempty};
      A_BITWIDTH: rd_mux = 32'(BIT);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (rd_req) begin
      bus.rdata <= rd_mux;
    end
  end

  // Only the two clear bits of a STATUS write carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[31:4], bus.wdata[1:0]};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by
// randomized register/serial traffic, compared against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned CLOCK_RATE = 24_000_000;
  localparam int unsigned BAUD_RATE  = 115200;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BIT        = CLOCK_RATE / BAUD_RATE;
  // Edges from driving the start bit (just after an edge) to the stop-sample
  // edge: 2 synchronizer edges, 1 detect edge, then BIT/2 + 9*BIT.
  localparam int unsigned STOP_OFS   = 3 + BIT / 2 + 9 * BIT;

  logic clk;
  logic rst;
  logic uart_rx;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_ferr;

  function automatic void m_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (mq.size() < FIFO_DEPTH) mq.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return 32'h0;
    return 32'h100 | 32'(mq.pop_front());
  endfunction

  function automatic logic [31:0] m_status();
    return {24'b0, 4'(mq.size()), m_ferr, m_ovr, (mq.size() == FIFO_DEPTH), (mq.size() != 0)};
  endfunction

  function automatic void m_clear(input logic [31:0] w);
    if (w[2]) m_ovr = 1'b0;
    if (w[3]) m_ferr = 1'b0;
  endfunction

  // ---------------- stimulus tasks (entered just after a posedge) -----------
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.sel  = 1'b1;
    bus.wren = 1'b0;
    bus.addr = a;
    @(posedge clk); #1;
    d = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] w);
    bus.sel   = 1'b1;
    bus.wren  = 1'b1;
    bus.addr  = a;
    bus.wdata = w;
    @(posedge clk); #1;
    bus.sel  = 1'b0;
    bus.wren = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    uart_rx = stop_ok;
    repeat (BIT) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    drive_frame(b, stop_ok);
    m_frame(b, stop_ok);
  endtask

  task automatic chk_data(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = m_pop();
    bus_read(2'd0, d);
    check(tag, d, e);
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    bus_read(2'd1, d);
    check(tag, d, m_status());
  endtask

  task automatic write_status(input logic [31:0] w);
    bus_write(2'd1, w);
    m_clear(w);
  endtask

  logic [31:0] rd;
  logic [31:0] last;
  logic [31:0] w;
  logic [7:0]  b;
  bit          ok;

  initial begin
    rst       = 1'b1;
    uart_rx   = 1'b1;
    bus.sel   = 1'b0;
    bus.wren  = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    m_ovr     = 1'b0;
    m_ferr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset state
    check("reset_rdata", bus.rdata, 32'h0);
    chk_status("reset_status");
    bus_read(2'd2, rd);
    check("reset_bitwidth", rd, 32'd208);
    bus_read(2'd3, rd);
    check("reset_reserved", rd, 32'h0);
    chk_data("reset_data_empty");

    // Single byte
    send(8'hA5, 1'b1);
    check("single_model_status", m_status(), 32'h11);
    chk_status("single_status");
    bus_read(2'd0, rd);
    last = m_pop();
    check("single_data", rd, last);
    repeat (10) @(posedge clk);
    #1;
    check("rdata_hold", bus.rdata, 32'h1A5);
    chk_status("single_status_after");
    chk_data("single_data_empty");

    // Glitch then a valid frame
    uart_rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    chk_status("glitch_status");
    send(8'h3C, 1'b1);
    chk_data("glitch_next_frame");

    // Framing error
    send(8'h55, 1'b0);
    chk_status("ferr_status");
    chk_data("ferr_no_push");
    write_status(32'h08);
    chk_status("ferr_cleared");

    // Overrun
    for (int unsigned i = 1; i <= 5; i++) send(8'(i), 1'b1);
    chk_status("ovr_status");
    for (int unsigned i = 0; i < 5; i++) chk_data("ovr_drain");
    write_status(32'h04);
    chk_status("ovr_cleared");

    // Pop on the stop-sample cycle with FIFO full
    for (int unsigned i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1);
    fork
      drive_frame(8'h14, 1'b1);
      begin
        logic [31:0] e;
        logic [31:0] d;
        repeat (STOP_OFS - 1) @(posedge clk);
        #1;
        e = m_pop();
        bus_read(2'd0, d);
        check("sim_pop_data", d, e);
      end
    join
    m_frame(8'h14, 1'b1);
    chk_status("sim_pop_status");

    // W1C overrun on the same cycle a new overrun occurs
    fork
      drive_frame(8'h15, 1'b1);
      begin
        repeat (STOP_OFS - 1) @(posedge clk);
        #1;
        bus_write(2'd1, 32'h04);
      end
    join
    m_clear(32'h04);
    m_frame(8'h15, 1'b1);
    chk_status("sim_clr_status");
    write_status(32'h04);
    chk_status("sim_clr_after");
    for (int unsigned i = 0; i < 5; i++) chk_data("sim_drain");

    // Reset during data bit 3; 0xF8 keeps the line high from bit 3 onward
    send(8'h77, 1'b1);
    chk_status("pre_reset_status");
    fork
      drive_frame(8'hF8, 1'b1);
      begin
        repeat (4 * BIT + 50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_rdata", bus.rdata, 32'h0);
      end
    join
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    chk_status("midreset_status");
    bus_read(2'd2, rd);
    check("midreset_bitwidth", rd, 32'd208);
    chk_data("midreset_no_push");
    send(8'hC3, 1'b1);
    chk_data("midreset_next_frame");

    // Randomized traffic
    for (int unsigned it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin
          b  = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          send(b, ok);
          repeat ($urandom_range(1, 20)) @(posedge clk);
          #1;
        end
        2, 3: chk_data("rand_data");
        4:    chk_status("rand_status");
        5: begin
          w = $urandom;
          write_status(w);
          chk_status("rand_w1c");
        end
        6: begin
          w = $urandom;
          bus_write(2'($urandom_range(0, 1) * 2 + $urandom_range(0, 1) * ($urandom_range(0, 1) + 1) % 2 == 1 ? 3 : 2), w);
          bus_write(2'd0, w);
          chk_status("rand_ignored_write");
        end
        default: begin
          bus_read(2'd2, rd);
          check("rand_bitwidth", rd, 32'(BIT));
          bus_read(2'd3, rd);
          check("rand_reserved", rd, 32'h0);
        end
      endcase
    end
    chk_status("final_status");
    for (int unsigned i = 0; i <= FIFO_DEPTH; i++) chk_data("final_drain");
    chk_status("final_status_empty");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
